// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - bridges 256-bit line requests onto a 4x64-bit burst memory
// Optional ADAPTER_ADDR_CHECK_EN: read beats whose bmem_raddr line tag differs from the pending line are dropped.
module cacheline_adapter #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               dfp_addr,
  input  logic                      dfp_read,
  input  logic                      dfp_write,
  input  logic [BEAT_W*BEATS-1:0]   dfp_wdata,
  output logic [BEAT_W*BEATS-1:0]   dfp_rdata,
  output logic [31:0]               dfp_raddr,
  output logic                      dfp_resp,
  output logic [31:0]               bmem_addr,
  output logic                      bmem_read,
  output logic                      bmem_write,
  output logic [BEAT_W-1:0]         bmem_wdata,
  input  logic                      bmem_ready,
  input  logic [31:0]               bmem_raddr,
  input  logic [BEAT_W-1:0]         bmem_rdata,
  input  logic                      bmem_rvalid
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_BURST,
    RESP
  } state_t;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  state_t              r_state;
  logic [1:0]          r_rcnt;
  logic [1:0]          r_wcnt;
  logic [26:0]         r_line_addr;
  logic                r_dfp_resp;
  logic                r_bmem_write;
  logic [BEAT_W-1:0]   r_rbuf [BEATS];
  logic [BEAT_W-1:0]   r_wbuf [BEATS];

  logic                w_beat_ok;
  logic                w_unused;

`ifdef ADAPTER_ADDR_CHECK_EN
  assign w_beat_ok = bmem_rvalid && (bmem_raddr[31:5] == r_line_addr);
`else
  assign w_beat_ok = bmem_rvalid;
`endif

  assign w_unused = ^{dfp_addr[4:0], bmem_raddr};

  // The read strobe tracks bmem_ready combinationally so it is only raised in an accepting cycle.
  assign bmem_read  = (r_state == RD_REQ) && bmem_ready;
  assign bmem_write = r_bmem_write;
  assign bmem_addr  = {r_line_addr, 5'b0};
  assign bmem_wdata = r_wbuf[r_wcnt];
  assign dfp_resp   = r_dfp_resp;
  assign dfp_raddr  = {r_line_addr, 5'b0};

  for (genvar g = 0; g < BEATS; g++) begin : g_rdata
    assign dfp_rdata[g*BEAT_W +: BEAT_W] = r_rbuf[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rcnt       <= 2'd0;
      r_wcnt       <= 2'd0;
      r_line_addr  <= '0;
      r_dfp_resp   <= 1'b0;
      r_bmem_write <= 1'b0;
      for (int k = 0; k < BEATS; k++) begin
        r_rbuf[k] <= '0;
        r_wbuf[k] <= '0;
      end
    end else begin
      r_dfp_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          r_rcnt <= 2'd0;
          r_wcnt <= 2'd0;
          if (dfp_write || dfp_read) begin
            r_line_addr <= dfp_addr[31:5];
            for (int k = 0; k < BEATS; k++) begin
              r_wbuf[k] <= dfp_wdata[k*BEAT_W +: BEAT_W];
            end
          end
          // A simultaneous read and write is served as the write alone.
          if (dfp_write) begin
            r_state      <= WR_BURST;
            r_bmem_write <= 1'b1;
          end else if (dfp_read) begin
            r_state <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (w_beat_ok) begin
            r_rbuf[r_rcnt] <= bmem_rdata;
            r_rcnt         <= r_rcnt + 2'd1;
            if (r_rcnt == LAST_BEAT) begin
              r_state    <= RESP;
              r_dfp_resp <= 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (bmem_ready) begin
            r_wcnt <= r_wcnt + 2'd1;
            if (r_wcnt == LAST_BEAT) begin
              r_state      <= RESP;
              r_dfp_resp   <= 1'b1;
              r_bmem_write <= 1'b0;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 Parameters SHALL be: BEAT_W, 64, bmem beat width in bits; BEATS, 4, beats per line (line width = BEAT_W*BEATS = 256).
REQ-002 Reset SHALL be synchronous and active-high; the block has exactly one clock.
REQ-003 Ports SHALL be, as name direction width meaning:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- dfp_addr  in  32  cache line address; bits [4:0] ignored
- dfp_read  in  1  line read request, held until dfp_resp
- dfp_write  in  1  line write request, held until dfp_resp
- dfp_wdata  in  256  write line; beat k = bits [64k+63:64k]
- dfp_rdata  out  256  read line, valid only while dfp_resp=1
- dfp_raddr  out  32  line address of the returned read data
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  burst address, {addr[31:5],5'b0}
- bmem_read  out  1  read burst request, one-cycle pulse
- bmem_write  out  1  write beat strobe
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory can accept a request or write beat
- bmem_raddr  in  32  address tag of returning read beats
- bmem_rdata  in  64  read beat data
- bmem_rvalid  in  1  read beat valid

Function
REQ-004 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP.
REQ-005 IDLE: dfp_write=1 -> WR_BURST; else dfp_read=1 -> RD_REQ; both high -> write only, no read issued.
REQ-006 Request entry SHALL latch dfp_addr[31:5] and dfp_wdata; later dfp input changes are ignored until RESP.
REQ-007 RD_REQ: bmem_read=1 and bmem_addr valid only in cycles with bmem_ready=1; that cycle -> RD_WAIT; bmem_ready=0 -> stay, bmem_read=0.
REQ-008 RD_WAIT: each bmem_rvalid=1 cycle stores bmem_rdata into beat slot 0,1,2,3 in arrival order; gaps between beats permitted.
REQ-009 Fourth beat accepted -> RESP next cycle; dfp_rdata = {b3,b2,b1,b0}, dfp_raddr = latched line address.
REQ-010 WR_BURST: bmem_write=1, bmem_addr = latched address, bmem_wdata = beat[wcnt]; wcnt advances only on bmem_ready=1; beat 3 accepted -> RESP.
REQ-011 RESP: dfp_resp=1 exactly one cycle -> IDLE; a new request is sampled no earlier than the cycle after RESP.
REQ-012 Read latency with ready memory: dfp_resp 1 cycle after the cycle of the fourth rvalid.
REQ-013 Beat and write counters SHALL be 2-bit, wrap 3->0 on completion, cleared in IDLE.
REQ-014 bmem_rvalid outside RD_WAIT SHALL be ignored.
REQ-015 bmem_read and bmem_write SHALL never be high in the same cycle.

Reset
REQ-016 Under rst: state=IDLE, counters=0, beat buffers=0; dfp_resp, dfp_rdata, dfp_raddr, bmem_read, bmem_write, bmem_addr, bmem_wdata = 0.
REQ-017 rst mid-burst SHALL abort: partial beats discarded, no dfp_resp issued, IDLE on the first cycle after rst deasserts.

Configuration
REQ-018 With ADAPTER_ADDR_CHECK_EN defined, an RD_WAIT beat is accepted only if bmem_raddr[31:5] equals the latched line address; mismatched beats are dropped and do not advance the count.
REQ-019 Without ADAPTER_ADDR_CHECK_EN, every RD_WAIT beat is accepted regardless of bmem_raddr.

Verification
REQ-020 Read 0x1000_0024, bmem_ready=1, 4 consecutive beats A0..A3 -> single bmem_read pulse with addr 0x1000_0020; dfp_resp 1 cycle after A3; dfp_rdata={A3,A2,A1,A0}; dfp_raddr=0x1000_0020.
REQ-021 Write 0x0000_0040, wdata beats W0..W3, bmem_ready low on beat 2 for 3 cycles -> bmem_wdata holds W2 for 4 cycles; dfp_resp once, after W3 accepted.
REQ-022 dfp_read=dfp_write=1 -> write burst only, no bmem_read pulse, one dfp_resp.
REQ-023 rst asserted after 2 read beats, then a new read with beats B0..B3 -> no resp for the aborted read; dfp_rdata={B3,B2,B1,B0}.
REQ-024 ADAPTER_ADDR_CHECK_EN defined, stray beat with bmem_raddr=0x2000_0000 inside read of 0x1000_0000 -> beat dropped, response holds only matching beats; macro undefined -> stray beat lands in slot 0.
